// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: CDB result record plus project defaults for the
// execute-stage result collector.
package rv32i_types;

    localparam int ROB_IDX_W     = 5;
    localparam int PREG_W        = 6;
    localparam int NUM_EXEC_FU   = 5;
    localparam int NUM_CDB_PORTS = 2;
    localparam int CDB_BUF_DEPTH = 2;

    typedef enum logic [2:0] {
        FU_ADD = 3'd0,
        FU_MUL = 3'd1,
        FU_DIV = 3'd2,
        FU_BR  = 3'd3,
        FU_MEM = 3'd4
    } fu_id_e;

    typedef struct packed {
        logic                 valid;
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [PREG_W-1:0]    pd_s;
        logic [31:0]          rd_v;
    } cdb_t;

endpackage

// File: rtl/cdb_result_fifo.sv
// Small per-FU result FIFO: wrapping pointers plus an explicit count, flushable
// in one cycle. Push is ignored when full and pop is ignored when empty.
module cdb_result_fifo
    import rv32i_types::*;
#(
    parameter  int BUF_DEPTH = CDB_BUF_DEPTH,
    localparam int PTR_W     = $clog2(BUF_DEPTH),
    localparam int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  cdb_t             push_data,
    output cdb_t             head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    cdb_t             mem [BUF_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(BUF_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)
                count <= count + CNT_W'(1);
            else if (!do_push && do_pop)
                count <= count - CNT_W'(1);
        end
    end

    // Storage needs no reset: count and pointers alone decide what is live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/execute_cdb_arbiter.sv
// Collects FU results into per-unit FIFOs and grants up to NUM_CDB per cycle onto
// the CDB with rotating priority. Define EXECUTE_CDB_BYPASS_EN for 0-cycle bypass.
module execute_cdb_arbiter
    import rv32i_types::*;
#(
    parameter  int NUM_FU    = NUM_EXEC_FU,
    parameter  int NUM_CDB   = NUM_CDB_PORTS,
    parameter  int BUF_DEPTH = CDB_BUF_DEPTH,
    localparam int CNT_W     = $clog2(BUF_DEPTH + 1),
    localparam int OCC_W     = $clog2(NUM_FU * BUF_DEPTH + 1),
    localparam int RR_W      = $clog2(NUM_FU),
    localparam int RANK_W    = $clog2(NUM_FU + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             global_branch_signal,
    input  cdb_t             fu_cdb    [NUM_FU],
    output logic             fu_ready  [NUM_FU],
    output cdb_t             cdb_out   [NUM_CDB],
    output logic             overflow,
    output logic [OCC_W-1:0] occupancy
);

    cdb_t              fifo_head  [NUM_FU];
    logic [CNT_W-1:0]  fifo_count [NUM_FU];
    cdb_t              cand_data  [NUM_FU];
    logic [RR_W-1:0]   offset     [NUM_FU];
    logic [RANK_W-1:0] rank       [NUM_FU];
    logic [NUM_FU-1:0] fifo_full;
    logic [NUM_FU-1:0] fifo_empty;
    logic [NUM_FU-1:0] cand_valid;
    logic [NUM_FU-1:0] cand_byp;
    logic [NUM_FU-1:0] grant;
    logic [NUM_FU-1:0] push;
    logic [NUM_FU-1:0] pop;
    logic [RR_W-1:0]   rr_ptr;
    logic [RR_W-1:0]   rr_next;
    logic [RR_W-1:0]   max_off;
    logic [RR_W:0]     rr_sum;
    logic              any_grant;
    logic              drop;

    // Scan distance of FU idx from the current round-robin start point.
    function automatic logic [RR_W-1:0] dist_from_rr(input int idx, input logic [RR_W-1:0] base);
        logic [RR_W:0] d;
        d = (RR_W+1)'(idx) + (RR_W+1)'(NUM_FU) - {1'b0, base};
        if (d >= (RR_W+1)'(NUM_FU)) d = d - (RR_W+1)'(NUM_FU);
        return d[RR_W-1:0];
    endfunction

    for (genvar g = 0; g < NUM_FU; g++) begin : gen_fu
        cdb_result_fifo #(
            .BUF_DEPTH (BUF_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push[g]),
            .pop       (pop[g]),
            .flush     (global_branch_signal),
            .push_data (fu_cdb[g]),
            .head      (fifo_head[g]),
            .count     (fifo_count[g]),
            .full      (fifo_full[g]),
            .empty     (fifo_empty[g])
        );

`ifdef EXECUTE_CDB_BYPASS_EN
        assign cand_byp[g] = fifo_empty[g] && fu_cdb[g].valid;
`else
        assign cand_byp[g] = 1'b0;
`endif

        // A bypassed input that wins is consumed directly and never stored.
        assign cand_valid[g] = !fifo_empty[g] || cand_byp[g];
        assign cand_data[g]  = cand_byp[g] ? fu_cdb[g] : fifo_head[g];
        assign fu_ready[g]   = !fifo_full[g];
        assign push[g]       = fu_cdb[g].valid && !fifo_full[g] && !(cand_byp[g] && grant[g]);
        assign pop[g]        = grant[g] && !cand_byp[g];
    end

    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            offset[i] = dist_from_rr(i, rr_ptr);
        end
    end

    // Rank = how many competing candidates sit earlier in the rotating scan;
    // the first NUM_CDB ranks win and the rank doubles as the port number.
    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            rank[i] = '0;
            for (int j = 0; j < NUM_FU; j++) begin
                if (cand_valid[j] && (offset[j] < offset[i])) rank[i] = rank[i] + RANK_W'(1);
            end
            grant[i] = cand_valid[i] && (rank[i] < RANK_W'(NUM_CDB));
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_CDB; p++) begin
            cdb_out[p] = '0;
        end
        if (!global_branch_signal) begin
            for (int p = 0; p < NUM_CDB; p++) begin
                for (int i = 0; i < NUM_FU; i++) begin
                    if (grant[i] && (rank[i] == RANK_W'(p))) cdb_out[p] = cand_data[i];
                end
            end
        end
    end

    // The last granted FU is the one farthest along the scan; restart just past it.
    always_comb begin
        any_grant = |grant;
        max_off   = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (grant[i] && (offset[i] > max_off)) max_off = offset[i];
        end
        rr_sum = {1'b0, rr_ptr} + {1'b0, max_off} + (RR_W+1)'(1);
        if (rr_sum >= (RR_W+1)'(NUM_FU)) rr_sum = rr_sum - (RR_W+1)'(NUM_FU);
        rr_next = rr_sum[RR_W-1:0];
    end

    always_comb begin
        drop      = 1'b0;
        occupancy = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (fu_cdb[i].valid && fifo_full[i]) drop = 1'b1;
            occupancy = occupancy + OCC_W'(fifo_count[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (global_branch_signal) begin
            rr_ptr <= '0;
        end else if (any_grant) begin
            rr_ptr <= rr_next;
        end
    end

    // Sticky until reset; a flush does not clear it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop && !global_branch_signal) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_execute_cdb_arbiter.sv
// Bench for execute_cdb_arbiter: directed vector table, hand-written corner
// sequences and randomized traffic checked against a queue-based model.
module tb_execute_cdb_arbiter;
    import rv32i_types::*;

    localparam int NUM_FU    = 5;
    localparam int NUM_CDB   = 2;
    localparam int BUF_DEPTH = 2;
    localparam int OCC_W     = $clog2(NUM_FU * BUF_DEPTH + 1);
    localparam int NUM_VECS  = 15;

    typedef struct {
        logic [NUM_FU-1:0] vmask;
        logic              flush;
        int                rob_base;
        int                e0fu;
        int                e0rob;
        int                e1fu;
        int                e1rob;
        int                eocc;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             gbs;
    cdb_t             fu_cdb   [NUM_FU];
    logic             fu_ready [NUM_FU];
    cdb_t             cdb_out  [NUM_CDB];
    logic             overflow;
    logic [OCC_W-1:0] occupancy;

    int total = 0;
    int bad   = 0;

    vec_t vecs [NUM_VECS];

    // Reference model: one queue per FU, plain integer round-robin start.
    cdb_t model_q [NUM_FU][$];
    int   model_rr;
    bit   model_ovf;
    int   model_last;
    cdb_t exp_out     [NUM_CDB];
    bit   model_grant [NUM_FU];
    bit   model_byp   [NUM_FU];
    bit   saw_not_ready4;

    always #5 clk = ~clk;

    execute_cdb_arbiter #(
        .NUM_FU    (NUM_FU),
        .NUM_CDB   (NUM_CDB),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .global_branch_signal (gbs),
        .fu_cdb               (fu_cdb),
        .fu_ready             (fu_ready),
        .cdb_out              (cdb_out),
        .overflow             (overflow),
        .occupancy            (occupancy)
    );

    function automatic cdb_t make_result(input int fu, input int rob);
        cdb_t r;
        r.valid   = 1'b1;
        r.rob_idx = 5'(rob);
        r.pd_s    = 6'(fu * 8 + rob);
        r.rd_v    = 32'h1234 + 32'(fu) * 32'h10000 + 32'(rob ^ 3) * 32'h1000000;
        return r;
    endfunction

    function automatic cdb_t expect_port(input int fu, input int rob);
        cdb_t r;
        r = '0;
        if (fu >= 0) r = make_result(fu, rob);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_FU-1:0] vmask, input logic flush, input int rob_base);
        @(negedge clk);
        for (int i = 0; i < NUM_FU; i++) begin
            fu_cdb[i] = vmask[i] ? make_result(i, rob_base + i) : '0;
        end
        gbs = flush;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_FU; i++) model_q[i].delete();
        model_rr  = 0;
        model_ovf = 1'b0;
    endtask

    task automatic model_eval();
        int n;
        n          = 0;
        model_last = -1;
        for (int p = 0; p < NUM_CDB; p++) exp_out[p] = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            model_grant[i] = 1'b0;
            model_byp[i]   = 1'b0;
        end
        for (int k = 0; k < NUM_FU; k++) begin
            int   i;
            bit   has;
            cdb_t cand;
            i    = (model_rr + k) % NUM_FU;
            has  = 1'b0;
            cand = '0;
            if (model_q[i].size() > 0) begin
                has  = 1'b1;
                cand = model_q[i][0];
            end
`ifdef EXECUTE_CDB_BYPASS_EN
            else if (fu_cdb[i].valid) begin
                has          = 1'b1;
                cand         = fu_cdb[i];
                model_byp[i] = 1'b1;
            end
`endif
            if (has && n < NUM_CDB) begin
                if (!gbs) exp_out[n] = cand;
                model_grant[i] = 1'b1;
                model_last     = i;
                n++;
            end
        end
    endtask

    task automatic model_commit();
        if (gbs) begin
            for (int i = 0; i < NUM_FU; i++) model_q[i].delete();
            model_rr = 0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                int sz;
                sz = model_q[i].size();
                if (model_grant[i] && !model_byp[i]) void'(model_q[i].pop_front());
                if (fu_cdb[i].valid && !(model_grant[i] && model_byp[i])) begin
                    if (sz < BUF_DEPTH) model_q[i].push_back(fu_cdb[i]);
                    else model_ovf = 1'b1;
                end
            end
            if (model_last >= 0) model_rr = (model_last + 1) % NUM_FU;
        end
    endtask

    // Called right after inputs are driven at the falling edge.
    task automatic model_cycle();
        int occ;
        model_eval();
        #1;
        occ = 0;
        for (int p = 0; p < NUM_CDB; p++)
            checkOutput($sformatf("cdb_out[%0d]", p), 64'(cdb_out[p]), 64'(exp_out[p]));
        for (int i = 0; i < NUM_FU; i++) begin
            checkOutput($sformatf("fu_ready[%0d]", i), 64'(fu_ready[i]), 64'(model_q[i].size() < BUF_DEPTH));
            occ += model_q[i].size();
        end
        checkOutput("occupancy", 64'(occupancy), 64'(occ));
        checkOutput("overflow", 64'(overflow), 64'(model_ovf));
        if (!fu_ready[4]) saw_not_ready4 = 1'b1;
        model_commit();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        gbs   = 1'b0;
        for (int i = 0; i < NUM_FU; i++) fu_cdb[i] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0]  = '{5'b11111, 1'b0,  0, -1,  0, -1,  0, 0};
        vecs[1]  = '{5'b00000, 1'b0,  0,  0,  0,  1,  1, 5};
        vecs[2]  = '{5'b00000, 1'b0,  0,  2,  2,  3,  3, 3};
        vecs[3]  = '{5'b00000, 1'b0,  0,  4,  4, -1,  0, 1};
        vecs[4]  = '{5'b00000, 1'b0,  0, -1,  0, -1,  0, 0};
        vecs[5]  = '{5'b00110, 1'b0,  8, -1,  0, -1,  0, 0};
        vecs[6]  = '{5'b00000, 1'b0,  0,  1,  9,  2, 10, 2};
        vecs[7]  = '{5'b00011, 1'b0, 16, -1,  0, -1,  0, 0};
        vecs[8]  = '{5'b00000, 1'b0,  0,  0, 16,  1, 17, 2};
        vecs[9]  = '{5'b00001, 1'b0,  3, -1,  0, -1,  0, 0};
        vecs[10] = '{5'b00000, 1'b0,  0,  0,  3, -1,  0, 1};
        vecs[11] = '{5'b00000, 1'b0,  0, -1,  0, -1,  0, 0};
        vecs[12] = '{5'b11111, 1'b0, 20, -1,  0, -1,  0, 0};
        vecs[13] = '{5'b00001, 1'b1, 24, -1,  0, -1,  0, 5};
        vecs[14] = '{5'b00000, 1'b0,  0, -1,  0, -1,  0, 0};

        saw_not_ready4 = 1'b0;
        rst_n = 1'b0;
        gbs   = 1'b0;
        for (int i = 0; i < NUM_FU; i++) fu_cdb[i] = '0;
        model_reset();

        #12;
        for (int p = 0; p < NUM_CDB; p++)
            checkOutput($sformatf("reset cdb_out[%0d]", p), 64'(cdb_out[p]), 64'(0));
        for (int i = 0; i < NUM_FU; i++)
            checkOutput($sformatf("reset fu_ready[%0d]", i), 64'(fu_ready[i]), 64'(1));
        checkOutput("reset occupancy", 64'(occupancy), 64'(0));
        checkOutput("reset overflow", 64'(overflow), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

`ifndef EXECUTE_CDB_BYPASS_EN
        for (int r = 0; r < NUM_VECS; r++) begin
            applyStimulus(vecs[r].vmask, vecs[r].flush, vecs[r].rob_base);
            #1;
            checkOutput($sformatf("row%0d port0", r), 64'(cdb_out[0]), 64'(expect_port(vecs[r].e0fu, vecs[r].e0rob)));
            checkOutput($sformatf("row%0d port1", r), 64'(cdb_out[1]), 64'(expect_port(vecs[r].e1fu, vecs[r].e1rob)));
            checkOutput($sformatf("row%0d occupancy", r), 64'(occupancy), 64'(vecs[r].eocc));
        end
`else
        applyStimulus(5'b01000, 1'b0, 7);
        #1;
        checkOutput("bypass same-cycle port0", 64'(cdb_out[0]), 64'(make_result(3, 7)));
        checkOutput("bypass port1 idle", 64'(cdb_out[1]), 64'(0));
        applyStimulus(5'b00000, 1'b0, 0);
        #1;
        checkOutput("bypass occupancy", 64'(occupancy), 64'(0));
`endif

        do_reset();

        // Backpressure: every FU floods, two ports cannot keep up.
        for (int c = 0; c < 6; c++) begin
            applyStimulus(5'b11111, 1'b0, 8 * c);
            model_cycle();
        end
        checkOutput("fu4 not ready seen", 64'(saw_not_ready4), 64'(1));
        checkOutput("overflow sticky", 64'(overflow), 64'(1));

        // Flush with a simultaneous new result on FU0.
        applyStimulus(5'b00001, 1'b1, 40);
        model_cycle();
        applyStimulus(5'b00000, 1'b0, 0);
        model_cycle();
        checkOutput("occupancy after flush", 64'(occupancy), 64'(0));
        checkOutput("overflow kept by flush", 64'(overflow), 64'(1));

        // Asynchronous reset in the middle of a cycle with 3 entries buffered.
        applyStimulus(5'b00111, 1'b0, 48);
        model_cycle();
        applyStimulus(5'b00000, 1'b0, 0);
        #1;
        checkOutput("occupancy before async reset", 64'(occupancy), 64'(3));
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset occupancy", 64'(occupancy), 64'(0));
        for (int i = 0; i < NUM_FU; i++)
            checkOutput($sformatf("async reset fu_ready[%0d]", i), 64'(fu_ready[i]), 64'(1));
        checkOutput("async reset cdb_out[0]", 64'(cdb_out[0]), 64'(0));
        checkOutput("async reset overflow", 64'(overflow), 64'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic at several densities with occasional flushes.
        for (int blk = 0; blk < 4; blk++) begin
            int density;
            density = (blk == 0) ? 30 : (blk == 1) ? 60 : (blk == 2) ? 90 : 50;
            for (int c = 0; c < 100; c++) begin
                @(negedge clk);
                for (int i = 0; i < NUM_FU; i++) begin
                    cdb_t r;
                    r.rob_idx = 5'($urandom);
                    r.pd_s    = 6'($urandom);
                    r.rd_v    = $urandom;
                    r.valid   = ($urandom_range(99) < density);
                    fu_cdb[i] = r;
                end
                gbs = ($urandom_range(39) == 0);
                model_cycle();
            end
        end

        @(negedge clk);
        gbs = 1'b0;
        for (int i = 0; i < NUM_FU; i++) fu_cdb[i] = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
